// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, common command bytes
// and the on-wire frame builder.
package ps2_pkg;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_INHIBIT  = 3'd1;
   localparam logic [2:0] ST_SEND     = 3'd2;
   localparam logic [2:0] ST_STOP     = 3'd3;
   localparam logic [2:0] ST_ACK      = 3'd4;
   localparam logic [2:0] ST_WAITIDLE = 3'd5;

   localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_ACK        = 8'hFA;

   // {odd parity, data}; shifted out LSB first
   function automatic logic [8:0] ps2_frame(input logic [7:0] d);
      return {~^d, d};
   endfunction
endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a FILTER_LEN-sample
// deglitcher on CLK with a one-cycle falling-edge strobe.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic resetn,
   input  logic i_clk,
   input  logic i_dat,
   output logic o_clk_f,
   output logic o_dat_s,
   output logic o_fall
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    r_clk_sync;
   logic [1:0]    r_dat_sync;
   logic [CW-1:0] r_cnt;
   logic          r_clk_f;
   logic          r_fall;

   // Idle bus level is high, so everything resets to 1.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_cnt      <= '0;
         r_clk_f    <= 1'b1;
         r_fall     <= 1'b0;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_clk};
         r_dat_sync <= {r_dat_sync[0], i_dat};
         r_fall     <= 1'b0;
         if (r_clk_sync[1] == r_clk_f) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt   <= '0;
            r_clk_f <= r_clk_sync[1];
            r_fall  <= r_clk_f;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_clk_f = r_clk_f;
   assign o_dat_s = r_dat_sync[1];
   assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data +
// odd parity + stop clocked by the device, then ack sampling.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 750000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          w_clk_f;
   logic          w_dat_s;
   logic          w_fall;

   logic [2:0]    r_state;
   logic [8:0]    r_shift;
   logic [3:0]    r_bitcnt;
   logic [IW-1:0] r_icnt;
   logic [TW-1:0] r_tcnt;
   logic          r_busy;
   logic          r_done;
   logic          r_ack_ok;
   logic          r_error;
   logic          r_clk_oe;
   logic          r_dat_oe;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
      .clock   (clock),
      .resetn  (resetn),
      .i_clk   (ps2_clk_i),
      .i_dat   (ps2_dat_i),
      .o_clk_f (w_clk_f),
      .o_dat_s (w_dat_s),
      .o_fall  (w_fall)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_icnt   <= '0;
         r_tcnt   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ack_ok <= 1'b0;
         r_error  <= 1'b0;
         r_clk_oe <= 1'b0;
         r_dat_oe <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_clk_oe <= 1'b0;
               r_dat_oe <= 1'b0;
               if (tx_start) begin
                  r_shift  <= ps2_frame(tx_data);
                  r_busy   <= 1'b1;
                  r_ack_ok <= 1'b0;
                  r_icnt   <= '0;
                  r_clk_oe <= 1'b1;
                  r_state  <= ST_INHIBIT;
               end
            end
            // Start bit goes low one cycle before CLK is released.
            ST_INHIBIT: begin
               r_icnt <= r_icnt + IW'(1);
               if (r_icnt == IW'(INHIBIT_CYCLES - 2))
                  r_dat_oe <= 1'b1;
               if (r_icnt == IW'(INHIBIT_CYCLES - 1)) begin
                  r_clk_oe <= 1'b0;
                  r_bitcnt <= '0;
                  r_tcnt   <= '0;
                  r_state  <= ST_SEND;
               end
            end
            // Device-clocked phases share the timeout; a fall beats expiry.
            default: begin
               if (w_fall) r_tcnt <= '0;
               else        r_tcnt <= r_tcnt + TW'(1);
               if (!w_fall && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_clk_oe <= 1'b0;
                  r_dat_oe <= 1'b0;
                  r_done   <= 1'b1;
                  r_error  <= 1'b1;
                  r_ack_ok <= 1'b0;
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  case (r_state)
                     ST_SEND: if (w_fall) begin
                        r_dat_oe <= ~r_shift[0];
                        r_shift  <= {1'b0, r_shift[8:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd8) r_state <= ST_STOP;
                     end
                     ST_STOP: if (w_fall) begin
                        r_dat_oe <= 1'b0;
                        r_state  <= ST_ACK;
                     end
                     ST_ACK: if (w_fall) begin
                        r_ack_ok <= ~w_dat_s;
                        r_state  <= ST_WAITIDLE;
                     end
                     ST_WAITIDLE: if (w_clk_f && w_dat_s) begin
                        r_done  <= 1'b1;
                        r_error <= ~r_ack_ok;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                     end
                     default: begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign ack_ok     = r_ack_ok;
   assign error      = r_error;
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain pins, frame
// scoreboard, inhibit/timeout/no-ack/reset scenarios.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 60;
   localparam int TO   = 2000;
   localparam int HALF = 40;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       busy, done, ack_ok, error, ps2_clk_oe, ps2_dat_oe;
   logic       ps2_clk_i, ps2_dat_i;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

   always #5 clock = ~clock;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .error      (error),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   typedef struct {
      logic [10:0] frame;
      logic        ack;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // output monitor
   int   done_cnt = 0, done_wide = 0, oe_rises = 0, inh_len = 0, run = 0;
   logic last_ack = 1'b0, last_err = 1'b0, prev_done = 1'b0, prev_clk_oe = 1'b0;
   logic dat_seen = 1'b0;
   always @(negedge clock) begin
      if (done) begin
         done_cnt++;
         last_ack = ack_ok;
         last_err = error;
      end
      if (done && prev_done) done_wide++;
      prev_done = done;
      if (ps2_clk_oe && !prev_clk_oe) begin
         oe_rises++;
         run = 0;
         dat_seen = 1'b0;
      end
      if (ps2_clk_oe) begin
         run++;
         if (ps2_dat_oe) dat_seen = 1'b1;
      end
      if (!ps2_clk_oe && prev_clk_oe) inh_len = run;
      prev_clk_oe = ps2_clk_oe;
   end

   task automatic pulse(input logic [7:0] d);
      @(negedge clock);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock);
      tx_start = 1'b0;
   endtask

   // Device: waits for request-to-send, clocks nclk cycles, samples on rises.
   task automatic dev_frame(input int nclk, input bit do_ack, output logic [10:0] got,
                            output bit bz_all);
      int w = 0;
      got = '1;
      bz_all = 1'b1;
      while (!(ps2_clk_i && !ps2_dat_i) && w < INH + 100) begin
         @(negedge clock);
         w++;
      end
      chk("rts", {ps2_clk_i, ps2_dat_i}, 2'b10);
      if (!(ps2_clk_i && !ps2_dat_i)) return;
      got[0] = ps2_dat_i;
      repeat (HALF) @(negedge clock);
      for (int i = 1; i <= 10 && i <= nclk; i++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clock);
         dev_clk_low = 1'b0;
         got[i] = ps2_dat_i;
         bz_all &= busy;
         repeat (HALF) @(negedge clock);
      end
      if (nclk >= 11) begin
         if (do_ack) dev_dat_low = 1'b1;
         repeat (5) @(negedge clock);
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clock);
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clock);
         dev_dat_low = 1'b0;
         repeat (5) @(negedge clock);
      end
   endtask

   task automatic send(input logic [7:0] d, input bit do_ack, input bit bump);
      exp_t e, x;
      logic [10:0] got;
      bit bz;
      int n0, w, ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      e.frame = {1'b1, (ones % 2 == 0), d, 1'b0};
      e.ack   = do_ack;
      e.err   = !do_ack;
      sb.push_back(e);
      n0 = done_cnt;
      pulse(d);
      if (bump) begin
         repeat (20) @(negedge clock);
         pulse(8'h3C);
      end
      dev_frame(11, do_ack, got, bz);
      w = 0;
      while (done_cnt == n0 && w < 500) begin
         @(negedge clock);
         w++;
      end
      chk("done_seen", done_cnt - n0, 1);
      x = sb.pop_front();
      chk("frame", got, x.frame);
      chk("ack_ok", last_ack, x.ack);
      chk("error", last_err, x.err);
      chk("busy_thru", bz, 1);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      int n, rises;
      logic [10:0] got;
      bit bz;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack", ack_ok, 0);
      chk("rst_err", error, 0);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_dat_oe", ps2_dat_oe, 0);
      resetn = 1'b1;
      repeat (5) @(negedge clock);

      send(PS2_CMD_SETLED, 1'b1, 1'b0);
      chk("inh_len", inh_len, INH);
      chk("dat_before_clk", dat_seen, 1);
      send(8'h01, 1'b1, 1'b0);
      send(PS2_CMD_RESET, 1'b1, 1'b0);

      // device silent -> timeout measured from CLK release
      pulse(8'h55);
      n = 0;
      while (!ps2_clk_oe && n < 100) begin @(negedge clock); n++; end
      n = 0;
      while (ps2_clk_oe && n < INH + 100) begin @(negedge clock); n++; end
      n = 0;
      while (!done && n < TO + 50) begin @(negedge clock); n++; end
      chk("to_lat", n, TO);
      chk("to_err", error, 1);
      chk("to_ack", ack_ok, 0);
      chk("to_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      repeat (5) @(negedge clock);
      chk("to_busy", busy, 0);

      // missing ack, with a start pulse while busy
      rises = oe_rises;
      send(8'hA5, 1'b0, 1'b1);
      repeat (INH + 50) @(negedge clock);
      chk("no_second_frame", oe_rises - rises, 1);

      // async reset after the 4th data bit
      pulse(8'h00);
      dev_frame(4, 1'b0, got, bz);
      chk("part_frame", got[4:0], 5'b00000);
      chk("pre_rst_dat_oe", ps2_dat_oe, 1);
      chk("pre_rst_busy", busy, 1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_clk_oe", ps2_clk_oe, 0);
      chk("arst_dat_oe", ps2_dat_oe, 0);
      chk("arst_busy", busy, 0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (5) @(negedge clock);
      send(8'hF4, 1'b1, 1'b0);

      chk("done_width", done_wide, 0);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule
